// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA receive path.
// Holds the 640x480@60 timing constants (identical to the transmitter),
// the capture FSM state type and the pixel coordinate width.
package vga_timing_pkg;

    localparam int COORD_W      = 10;

    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    // Extra clocks past a nominal line before a missing hsync is declared.
    localparam int H_TIMEOUT_MARGIN = 16;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        LOCKED
    } rx_state_e;

endpackage

// File: rtl/vga_rx_capture_if.sv
// Pixel write stream produced by vga_rx_capture.
//   pix_wr_en   : one-cycle strobe per captured active pixel
//   pix_x/pix_y : pixel coordinates
//   pix_data    : captured 24-bit pixel value
//   frame_start : strobe qualifier marking pixel (0,0)
// master = capture block, slave = frame buffer / write-back consumer.
interface vga_rx_capture_if;
    import vga_timing_pkg::*;

    logic        pix_wr_en;
    coord_t      pix_x;
    coord_t      pix_y;
    logic [23:0] pix_data;
    logic        frame_start;

    modport master (output pix_wr_en, pix_x, pix_y, pix_data, frame_start);
    modport slave  (input  pix_wr_en, pix_x, pix_y, pix_data, frame_start);
endinterface

// File: rtl/vga_sync_edge.sv
// Two-stage sync register with assert-edge detection.
//   clk, rst    : pixel clock, synchronous active-high reset
//   sync_in     : raw hsync or vsync from the transmitter
//   assert_edge : high for one cycle when stage 1 enters the asserted level
//                 while stage 2 is still deasserted
// Both stages reset to the deasserted level so no false edge follows reset.
module vga_sync_edge #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic assert_edge
);

    logic s1, s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= ~POL;
            s2 <= ~POL;
        end else begin
            s1 <= sync_in;
            s2 <= s1;
        end
    end

    assign assert_edge = (s1 == POL) && (s2 != POL);

endmodule

// File: rtl/vga_rx_capture.sv
// VGA receive-side timing recovery and pixel capture.
//   clk, rst        : pixel clock, synchronous active-high reset
//   hsync, vsync    : syncs from the transmitter (asserted level SYNC_POL)
//   rgb_in          : pixel data aligned with the syncs
//   pix             : pixel write stream (vga_rx_capture_if.master)
//   locked          : timing currently matches the parameters
//   err, err_cnt    : violation pulse while locked, saturating count
// Optional (macro VGA_RX_CHECKSUM_EN):
//   frame_sum, sum_valid : per-frame mod-2^32 sum of captured pixels
module vga_rx_capture
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BACK   = VGA_H_BACK,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_TOTAL  = VGA_H_TOTAL,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BACK   = VGA_V_BACK,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_TOTAL  = VGA_V_TOTAL,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [23:0]      rgb_in,
    vga_rx_capture_if.master pix,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
`ifdef VGA_RX_CHECKSUM_EN
    ,
    output logic [31:0]      frame_sum,
    output logic             sum_valid
`endif
);

    localparam coord_t H_FIRST  = coord_t'(H_SYNC + H_BACK);
    localparam coord_t H_LAST   = coord_t'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam coord_t V_FIRST  = coord_t'(V_SYNC + V_BACK);
    localparam coord_t V_LAST   = coord_t'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam coord_t H_END    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_END    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_TMO    = coord_t'(H_TOTAL + H_TIMEOUT_MARGIN);

    rx_state_e   state;
    logic        hs_edge, vs_edge;
    logic [23:0] rgb_q;
    coord_t      h_cnt, v_cnt;
    logic        bad_line, bad_frame, violation, in_win;

    vga_sync_edge #(.POL(SYNC_POL)) u_hs (
        .clk         (clk),
        .rst         (rst),
        .sync_in     (hsync),
        .assert_edge (hs_edge)
    );

    vga_sync_edge #(.POL(SYNC_POL)) u_vs (
        .clk         (clk),
        .rst         (rst),
        .sync_in     (vsync),
        .assert_edge (vs_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= rgb_in;
    end

    // h_cnt saturates so a dead link holds at 1023 instead of wrapping
    // back into the capture window.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_edge)          h_cnt <= '0;
            else if (h_cnt != '1) h_cnt <= h_cnt + 1'b1;

            if (vs_edge)          v_cnt <= '0;
            else if (hs_edge)     v_cnt <= v_cnt + 1'b1;
        end
    end

    // Timeout is an equality test so a saturated counter reports only once.
    always_comb begin
        bad_line  = (hs_edge && (h_cnt != H_END)) || (!hs_edge && (h_cnt == H_TMO));
        bad_frame = vs_edge && (v_cnt != V_END);
        violation = bad_line || bad_frame;
        in_win    = (state == LOCKED) && !violation &&
                    (h_cnt >= H_FIRST) && (h_cnt <= H_LAST) &&
                    (v_cnt >= V_FIRST) && (v_cnt <= V_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_edge) state <= TRAIN;
                end
                TRAIN: begin
                    if (violation) begin
                        state <= IDLE;
                    end else if (vs_edge) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (violation) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        err    <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Coordinates and data only load inside the window, so the subtractions
    // never underflow and the last pixel holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix.pix_wr_en   <= 1'b0;
            pix.frame_start <= 1'b0;
            pix.pix_x       <= '0;
            pix.pix_y       <= '0;
            pix.pix_data    <= '0;
        end else begin
            pix.pix_wr_en   <= in_win;
            pix.frame_start <= in_win && (h_cnt == H_FIRST) && (v_cnt == V_FIRST);
            if (in_win) begin
                pix.pix_x    <= h_cnt - H_FIRST;
                pix.pix_y    <= v_cnt - V_FIRST;
                pix.pix_data <= rgb_q;
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [31:0] sum_acc, sum_next;
    logic        sum_latch, sum_abort;

    always_comb begin
        sum_next  = sum_acc + (pix.pix_wr_en ? {8'd0, pix.pix_data} : 32'd0);
        sum_latch = (state == LOCKED) && vs_edge && !violation;
        sum_abort = (state == LOCKED) && violation;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (sum_abort) begin
                sum_acc <= '0;
            end else if (sum_latch) begin
                frame_sum <= sum_next;
                sum_valid <= 1'b1;
                sum_acc   <= '0;
            end else begin
                sum_acc <= sum_next;
            end
        end
    end
`endif

endmodule
